quad_decoder: RTL and testbench



---
 rtl/quad_decoder_pkg.sv | 42 ++++
 rtl/quad_decoder_input_debouncer.sv | 45 ++++
 rtl/quad_decoder.sv | 121 ++++++++++++
 tb/tb_quad_decoder.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/quad_decoder_pkg.sv
// Shared definitions for the quadrature decoder: Gray state encodings,
// direction constants and the transition classifier.
package quad_decoder_pkg;

  localparam logic [1:0] S00 = 2'b00;
  localparam logic [1:0] S01 = 2'b01;
  localparam logic [1:0] S11 = 2'b11;
  localparam logic [1:0] S10 = 2'b10;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic [1:0] {
    MOVE_NONE,
    MOVE_CW,
    MOVE_CCW,
    MOVE_BAD
  } move_t;

  // Position of a {A,B} pair around the CW cycle 00 -> 01 -> 11 -> 10.
  function automatic logic [1:0] gray_pos(input logic [1:0] s);
    case (s)
      S00:     gray_pos = 2'd0;
      S01:     gray_pos = 2'd1;
      S11:     gray_pos = 2'd2;
      default: gray_pos = 2'd3;
    endcase
  endfunction

  // One position forward is CW, one back is CCW, two apart is a skipped state.
  function automatic move_t classify(input logic [1:0] prev, input logic [1:0] cur);
    logic [1:0] delta;
    delta = gray_pos(cur) - gray_pos(prev);
    case (delta)
      2'd0:    classify = MOVE_NONE;
      2'd1:    classify = MOVE_CW;
      2'd3:    classify = MOVE_CCW;
      default: classify = MOVE_BAD;
    endcase
  endfunction

endpackage

// File: rtl/quad_decoder_input_debouncer.sv
// Single-channel 2-FF synchroniser followed by a consecutive-mismatch
// debounce counter; a change is accepted after DEBOUNCE_CYCLES mismatches.
module input_debouncer #(
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_reg;
  logic             sync2_reg;
  logic             stable_reg;
  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg  <= 1'b0;
      sync2_reg  <= 1'b0;
      stable_reg <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      sync1_reg <= din;
      sync2_reg <= sync1_reg;
      // Any cycle where the synchronised level agrees restarts the count.
      if (sync2_reg != stable_reg) begin
        if (cnt_reg == CNT_LAST) begin
          stable_reg <= sync2_reg;
          cnt_reg    <= '0;
        end else begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end else begin
        cnt_reg <= '0;
      end
    end
  end

  assign dout = stable_reg;

endmodule

// File: rtl/quad_decoder.sv
// Quadrature encoder decoder: debounced A/B, Gray decode, step/dir/count/err.
// Define QUAD_X1_EN for x1 decode (step only on entry to state 00); default is x4.
module quad_decoder
  import quad_decoder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int COUNT_W         = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enc_a,
  input  logic               enc_b,
  output logic               step,
  output logic               dir,
  output logic [COUNT_W-1:0] count,
  output logic               err
);

  localparam int ARM_W = $clog2(DEBOUNCE_CYCLES + 3);
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(DEBOUNCE_CYCLES + 2);

  logic [1:0]         raw_pair;
  logic [1:0]         stable_pair;
  logic [1:0]         prev_reg;
  logic [ARM_W-1:0]   arm_cnt_reg;
  logic               arm_reg;
  logic               step_reg, step_next;
  logic               err_reg, err_next;
  logic               dir_reg, dir_next;
  logic [COUNT_W-1:0] count_reg, count_next;
  move_t              move;

  assign raw_pair = {enc_a, enc_b};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      input_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
        .clk (clk),
        .rst (rst),
        .din (raw_pair[gi]),
        .dout(stable_pair[gi])
      );
    end
  endgenerate

  assign move = classify(prev_reg, stable_pair);

  always_comb begin
    step_next  = 1'b0;
    err_next   = 1'b0;
    dir_next   = dir_reg;
    count_next = count_reg;
    // Until armed, the resting position is absorbed into prev_reg silently.
    if (arm_reg) begin
      case (move)
        MOVE_CW: begin
`ifdef QUAD_X1_EN
          if (stable_pair == S00) begin
            step_next  = 1'b1;
            dir_next   = DIR_UP;
            count_next = count_reg + COUNT_W'(1);
          end
`else
          step_next  = 1'b1;
          dir_next   = DIR_UP;
          count_next = count_reg + COUNT_W'(1);
`endif
        end
        MOVE_CCW: begin
`ifdef QUAD_X1_EN
          if (stable_pair == S00) begin
            step_next  = 1'b1;
            dir_next   = DIR_DOWN;
            count_next = count_reg - COUNT_W'(1);
          end
`else
          step_next  = 1'b1;
          dir_next   = DIR_DOWN;
          count_next = count_reg - COUNT_W'(1);
`endif
        end
        MOVE_BAD: err_next = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_reg    <= S00;
      arm_cnt_reg <= '0;
      arm_reg     <= 1'b0;
      step_reg    <= 1'b0;
      err_reg     <= 1'b0;
      dir_reg     <= DIR_DOWN;
      count_reg   <= '0;
    end else begin
      prev_reg  <= stable_pair;
      step_reg  <= step_next;
      err_reg   <= err_next;
      dir_reg   <= dir_next;
      count_reg <= count_next;
      // Arm only after a resting non-00 level has had time to reach stable_pair.
      if (!arm_reg) begin
        if (arm_cnt_reg == ARM_LAST) begin
          arm_reg <= 1'b1;
        end else begin
          arm_cnt_reg <= arm_cnt_reg + ARM_W'(1);
        end
      end
    end
  end

  assign step  = step_reg;
  assign err   = err_reg;
  assign dir   = dir_reg;
  assign count = count_reg;

endmodule

// File: tb/tb_quad_decoder.sv
// Self-checking bench for quad_decoder: vector table, hand-written corner
// sequences and randomized stimulus against a cycle-level behavioural model.
module tb_quad_decoder;

  localparam int DC = 4;
  localparam int CW_ = 4;
`ifdef QUAD_X1_EN
  localparam bit X1 = 1'b1;
`else
  localparam bit X1 = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enc_a = 1'b0;
  logic          enc_b = 1'b0;
  logic          step;
  logic          dir;
  logic [CW_-1:0] count;
  logic          err;

  quad_decoder #(.DEBOUNCE_CYCLES(DC), .COUNT_W(CW_)) dut (
    .clk  (clk),
    .rst  (rst),
    .enc_a(enc_a),
    .enc_b(enc_b),
    .step (step),
    .dir  (dir),
    .count(count),
    .err  (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural model state; channel index 1 = A, 0 = B.
  logic [1:0] cw_seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  logic m_s1 [2];
  logic m_s2 [2];
  logic m_stab [2];
  int   m_run [2];
  logic [1:0] m_prev;
  int   m_since;
  int   m_step, m_err, m_dir, m_count;

  task automatic model_edge();
    logic [1:0] cur;
    bit is_cw, is_ccw;
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        m_s1[c] = 0; m_s2[c] = 0; m_stab[c] = 0; m_run[c] = 0;
      end
      m_prev = 0; m_since = 0;
      m_step = 0; m_err = 0; m_dir = 0; m_count = 0;
    end else begin
      cur = {m_stab[1], m_stab[0]};
      m_step = 0; m_err = 0;
      if (m_since >= DC + 3 && cur != m_prev) begin
        is_cw = 0; is_ccw = 0;
        for (int i = 0; i < 4; i++) begin
          if (cw_seq[i] == m_prev && cw_seq[(i + 1) % 4] == cur) is_cw = 1;
          if (cw_seq[(i + 1) % 4] == m_prev && cw_seq[i] == cur) is_ccw = 1;
        end
        if (is_cw) begin
          if (!X1 || cur == 2'b00) begin
            m_step = 1; m_dir = 1; m_count = (m_count + 1) % 16;
          end
        end else if (is_ccw) begin
          if (!X1 || cur == 2'b00) begin
            m_step = 1; m_dir = 0; m_count = (m_count + 15) % 16;
          end
        end else begin
          m_err = 1;
        end
      end
      m_prev = cur;
      for (int c = 0; c < 2; c++) begin
        if (m_s2[c] != m_stab[c]) begin
          m_run[c]++;
          if (m_run[c] == DC) begin
            m_stab[c] = m_s2[c];
            m_run[c] = 0;
          end
        end else begin
          m_run[c] = 0;
        end
        m_s2[c] = m_s1[c];
      end
      m_s1[1] = enc_a;
      m_s1[0] = enc_b;
      if (m_since < 100000) m_since++;
    end
  endtask

  int step_seen, err_seen, tick_no, first_step;

  task automatic clear_obs();
    step_seen = 0; err_seen = 0; tick_no = 0; first_step = -1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    tick_no++;
    if (step) begin
      step_seen++;
      if (first_step < 0) first_step = tick_no;
    end
    if (err) err_seen++;
    chk("model_step", int'(step), m_step);
    chk("model_err", int'(err), m_err);
    chk("model_dir", int'(dir), m_dir);
    chk("model_count", int'(count), m_count);
    chk("step_err_excl", int'(step & err), 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  typedef struct {
    logic a;
    logic b;
    int   exp_steps;
    int   exp_errs;
    int   exp_count;
    int   exp_dir;
  } vec_t;

  vec_t tbl [8];

  initial begin
`ifdef QUAD_X1_EN
    tbl[0] = '{1'b0, 1'b1, 0, 0, 0, 0};
    tbl[1] = '{1'b1, 1'b1, 0, 0, 0, 0};
    tbl[2] = '{1'b1, 1'b0, 0, 0, 0, 0};
    tbl[3] = '{1'b0, 1'b0, 1, 0, 1, 1};
    tbl[4] = '{1'b1, 1'b0, 0, 0, 1, 1};
    tbl[5] = '{1'b0, 1'b0, 1, 0, 2, 1};
    tbl[6] = '{1'b1, 1'b1, 0, 1, 2, 1};
    tbl[7] = '{1'b0, 1'b0, 0, 1, 2, 1};
`else
    tbl[0] = '{1'b0, 1'b1, 1, 0, 1, 1};
    tbl[1] = '{1'b1, 1'b1, 1, 0, 2, 1};
    tbl[2] = '{1'b1, 1'b0, 1, 0, 3, 1};
    tbl[3] = '{1'b0, 1'b0, 1, 0, 4, 1};
    tbl[4] = '{1'b1, 1'b0, 1, 0, 3, 0};
    tbl[5] = '{1'b0, 1'b0, 1, 0, 4, 1};
    tbl[6] = '{1'b1, 1'b1, 0, 1, 4, 1};
    tbl[7] = '{1'b0, 1'b0, 0, 1, 4, 1};
`endif

    // Reset and idle.
    rst = 1; enc_a = 0; enc_b = 0;
    ticks(3);
    rst = 0;
    clear_obs();
    ticks(8);
    chk("reset_step", int'(step), 0);
    chk("reset_err", int'(err), 0);
    chk("reset_count", int'(count), 0);
    chk("reset_dir", int'(dir), 0);
    chk("reset_no_pulses", step_seen + err_seen, 0);

    // Table-driven transitions, each level held 10 cycles.
    for (int v = 0; v < 8; v++) begin
      enc_a = tbl[v].a; enc_b = tbl[v].b;
      clear_obs();
      ticks(10);
      chk("tbl_steps", step_seen, tbl[v].exp_steps);
      chk("tbl_errs", err_seen, tbl[v].exp_errs);
      chk("tbl_count", int'(count), tbl[v].exp_count);
      chk("tbl_dir", int'(dir), tbl[v].exp_dir);
      if (step_seen > 0) chk("tbl_latency", first_step, 2 + DC + 1);
      $display("vec %0d ab=%0b%0b steps=%0d errs=%0d count=%0d dir=%0d",
               v, tbl[v].a, tbl[v].b, step_seen, err_seen, count, dir);
    end

    // Glitch of 3 cycles on A must be rejected.
    enc_a = 1;
    clear_obs();
    ticks(3);
    enc_a = 0;
    ticks(12);
    chk("glitch_steps", step_seen, 0);
    chk("glitch_errs", err_seen, 0);
    chk("glitch_count", int'(count), tbl[7].exp_count);
    $display("glitch steps=%0d errs=%0d count=%0d", step_seen, err_seen, count);

    // Wrap below zero via CCW rotation from reset.
    rst = 1; ticks(2); rst = 0;
    ticks(10);
    enc_a = 1; enc_b = 0;
    ticks(10);
    chk("wrap_first_count", int'(count), X1 ? 0 : 15);
    chk("wrap_first_dir", int'(dir), 0);
    enc_a = 1; enc_b = 1; ticks(10);
    enc_a = 0; enc_b = 1; ticks(10);
    enc_a = 0; enc_b = 0; ticks(10);
    chk("wrap_cycle_count", int'(count), X1 ? 15 : 12);
    chk("wrap_cycle_dir", int'(dir), 0);
    $display("ccw cycle count=%0d dir=%0d", count, dir);

    // Resting at 11 through reset must arm silently.
    enc_a = 1; enc_b = 1;
    rst = 1; ticks(3); rst = 0;
    clear_obs();
    ticks(15);
    chk("arm11_steps", step_seen, 0);
    chk("arm11_errs", err_seen, 0);
    enc_b = 0;
    ticks(10);
    chk("arm11_cw_count", int'(count), X1 ? 0 : 1);
    chk("arm11_cw_dir", int'(dir), X1 ? 0 : 1);
    rst = 1;
    tick();
    chk("midrun_rst_count", int'(count), 0);
    rst = 0;
    $display("arm11 test count_after_rst=%0d", count);

    // Randomized segments with occasional reset.
    for (int s = 0; s < 400; s++) begin
      if ($urandom_range(0, 40) == 0) begin
        rst = 1;
        ticks(int'($urandom_range(1, 2)));
        rst = 0;
      end
      enc_a = 1'($urandom_range(0, 1));
      enc_b = 1'($urandom_range(0, 1));
      ticks(int'($urandom_range(1, 12)));
    end
    $display("random phase done count=%0d", count);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
